// File: rtl/spi_sram_bridge.sv
// SPI slave (mode 0) to single-cycle SRAM port bridge.
// Frames are CMD, ADDR, then DATA bytes. CMD 8'h02 writes and CMD 8'h03 reads.
// Reads prefetch, so the next byte is ready before it is shifted out.
module spi_sram_bridge #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              ss,
  output logic              re,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  output logic              busy
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DATA_W-1:0] CmdWrite = DATA_W'(8'h02);
  localparam logic [DATA_W-1:0] CmdRead  = DATA_W'(8'h03);
  localparam logic [CntW-1:0]   LastBit  = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StRdIssue, StRdWait, StData, StWrIssue, StIgnore
  } state_e;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_clk_prev, r_cs_prev;

  state_e              r_state;
  logic [CntW-1:0]     r_bitcnt;
  logic [DATA_W-2:0]   r_rx;
  logic [DATA_W-1:0]   r_tx;
  logic                r_is_read;
  logic                r_miso, r_ss, r_re, r_we, r_busy;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;

  logic w_clk, w_cs_n, w_mosi;
  logic w_clk_rise, w_clk_fall, w_cs_rise, w_cs_fall;
  logic w_last, w_shifting;
  logic [DATA_W-1:0] w_byte;

  assign w_clk      = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_clk & ~r_clk_prev;
  assign w_clk_fall = ~w_clk & r_clk_prev;
  assign w_cs_rise  = w_cs_n & ~r_cs_prev;
  assign w_cs_fall  = ~w_cs_n & r_cs_prev;
  assign w_byte     = {r_rx, w_mosi};
  assign w_last     = (r_bitcnt == LastBit);
  assign w_shifting = (r_state == StCmd) || (r_state == StAddr) ||
                      (r_state == StData) || (r_state == StIgnore);

  // Oversample the SPI pins; cs_n idles high so reset must not fake a falling edge.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_clk_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_clk_prev  <= w_clk;
      r_cs_prev   <= w_cs_n;
    end
  end

  // Frame decoder, SRAM strobes and MISO shifter, all outputs registered.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_bitcnt  <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_is_read <= 1'b0;
      r_miso    <= 1'b0;
      r_ss      <= 1'b1;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      r_re <= 1'b0;
      r_we <= 1'b0;
      r_ss <= 1'b1;
      if (w_cs_rise) begin
        r_state  <= StIdle;
        r_bitcnt <= '0;
        r_busy   <= 1'b0;
        r_miso   <= 1'b0;
      end else begin
        if (w_clk_rise && w_shifting) begin
          r_rx     <= w_byte[DATA_W-2:0];
          r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
        end
        unique case (r_state)
          StIdle: begin
            if (w_cs_fall) begin
              r_state  <= StCmd;
              r_busy   <= 1'b1;
              r_bitcnt <= '0;
              r_miso   <= 1'b0;
            end
          end
          StCmd: begin
            if (w_clk_rise && w_last) begin
              if (w_byte == CmdWrite) begin
                r_is_read <= 1'b0;
                r_state   <= StAddr;
              end else if (w_byte == CmdRead) begin
                r_is_read <= 1'b1;
                r_state   <= StAddr;
              end else begin
                r_state <= StIgnore;
              end
            end
          end
          StAddr: begin
            if (w_clk_rise && w_last) begin
              r_addr <= ADDR_W'(w_byte);
              if (r_is_read) begin
                r_state <= StRdIssue;
                r_re    <= 1'b1;
                r_ss    <= 1'b0;
              end else begin
                r_state <= StData;
              end
            end
          end
          StData: begin
            if (w_clk_rise && w_last) begin
              r_ss <= 1'b0;
              if (r_is_read) begin
                r_state <= StRdIssue;
                r_re    <= 1'b1;
              end else begin
                r_state <= StWrIssue;
                r_din   <= w_byte;
                r_we    <= 1'b1;
              end
            end else if (w_clk_fall && r_is_read && (r_bitcnt != '0)) begin
              // The falling edge after a byte's last rise belongs to the prefetch, not a shift.
              r_miso <= r_tx[DATA_W-1];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
          end
          StWrIssue: begin
            r_addr  <= r_addr + 1'b1;
            r_state <= StData;
          end
          StRdIssue: begin
            r_state <= StRdWait;
          end
          StRdWait: begin
            r_miso  <= dout[DATA_W-1];
            r_tx    <= {dout[DATA_W-2:0], 1'b0};
            r_addr  <= r_addr + 1'b1;
            r_state <= StData;
          end
          StIgnore: begin
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign spi_miso = r_miso;
  assign ss       = r_ss;
  assign re       = r_re;
  assign we       = r_we;
  assign addr     = r_addr;
  assign din      = r_din;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Bench for spi_sram_bridge: a behavioural SPI host, a behavioural SRAM, a strobe scoreboard,
// a table of frames and hand-written abort/reset sequences.
module tb_spi_sram_bridge;

  logic       sck, rst, spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic       ss, re, we, busy;
  logic [7:0] addr, din, dout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       is_we;
    logic [7:0] a;
    logic [7:0] d;
  } acc_t;
  acc_t exp_q[$];
  acc_t mon_e;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  adr;
    int          n;
    logic [23:0] data;
    logic [23:0] exp_rx;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] mem [256];

  spi_sram_bridge #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .sck     (sck),
    .rst     (rst),
    .spi_clk (spi_clk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .ss      (ss),
    .re      (re),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .busy    (busy)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  // Behavioural SRAM: read data valid the cycle after re.
  always @(posedge sck) begin
    if (!ss && we) mem[addr] <= din;
    if (!ss && re) dout <= mem[addr];
  end

  // Scoreboard: every strobe must match the oldest expected access.
  always @(negedge sck) begin
    if (!rst) begin
      n_cmp++;
      if ((ss !== !(re || we)) || (re && we)) begin
        n_bad++;
        $display("FAIL ss_strobe t=%0t: ss=%b re=%b we=%b", $time, ss, re, we);
      end
      if (re || we) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe t=%0t: we=%b re=%b addr=%h, none required",
                   $time, we, re, addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (we !== mon_e.is_we || addr !== mon_e.a || (mon_e.is_we && din !== mon_e.d)) begin
            n_bad++;
            $display("FAIL access t=%0t: got we=%b addr=%h din=%h, required we=%b addr=%h din=%h",
                     $time, we, addr, din, mon_e.is_we, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_q_empty(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected accesses never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Mode 0 host: drive MOSI while clk low, sample MISO just before the rising edge.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      #80;
      rx[7-i] = spi_miso;
      spi_clk = 1'b1;
      #80;
      spi_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] a, input int n,
                           input logic [23:0] data, output logic [23:0] rxd,
                           output logic [15:0] hdr);
    acc_t       e;
    logic [7:0] r;
    rxd = '0;
    if (cmd == 8'h02) begin
      for (int i = 0; i < n; i++) begin
        e.is_we = 1'b1;
        e.a     = a + 8'(i);
        e.d     = data[23-8*i -: 8];
        exp_q.push_back(e);
      end
    end else if (cmd == 8'h03) begin
      // One access per byte plus the trailing prefetch.
      for (int i = 0; i <= n; i++) begin
        e.is_we = 1'b0;
        e.a     = a + 8'(i);
        e.d     = 8'h00;
        exp_q.push_back(e);
      end
    end
    spi_cs_n = 1'b0;
    #80;
    spi_xfer(cmd, 8, r);
    hdr[15:8] = r;
    spi_xfer(a, 8, r);
    hdr[7:0] = r;
    for (int i = 0; i < n; i++) begin
      spi_xfer(data[23-8*i -: 8], 8, r);
      rxd[23-8*i -: 8] = r;
    end
    #80;
    spi_cs_n = 1'b1;
    #200;
  endtask

  logic [23:0] rxd;
  logic [15:0] hdr;
  logic [7:0]  r8;
  acc_t        ea;

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    dout     = 8'h00;
    rst      = 1'b1;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;

    vecs[0] = '{cmd: 8'h02, adr: 8'h10, n: 1, data: 24'hA50000, exp_rx: 24'h000000};
    vecs[1] = '{cmd: 8'h03, adr: 8'h10, n: 1, data: 24'h000000, exp_rx: 24'hA50000};
    vecs[2] = '{cmd: 8'h02, adr: 8'hFE, n: 3, data: 24'h112233, exp_rx: 24'h000000};
    vecs[3] = '{cmd: 8'h02, adr: 8'h20, n: 3, data: 24'h010203, exp_rx: 24'h000000};
    vecs[4] = '{cmd: 8'h03, adr: 8'h20, n: 3, data: 24'h000000, exp_rx: 24'h010203};
    vecs[5] = '{cmd: 8'h7F, adr: 8'h55, n: 1, data: 24'hFF0000, exp_rx: 24'h000000};

    #23;
    check("rst_ss", {7'd0, ss}, 8'h01);
    check("rst_re", {7'd0, re}, 8'h00);
    check("rst_we", {7'd0, we}, 8'h00);
    check("rst_addr", addr, 8'h00);
    check("rst_din", din, 8'h00);
    check("rst_miso", {7'd0, spi_miso}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    #9 rst = 1'b0;
    #100;

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].cmd, vecs[v].adr, vecs[v].n, vecs[v].data, rxd, hdr);
      check($sformatf("v%0d_miso_cmd", v), hdr[15:8], 8'h00);
      check($sformatf("v%0d_miso_addr", v), hdr[7:0], 8'h00);
      for (int i = 0; i < vecs[v].n; i++)
        check($sformatf("v%0d_miso_b%0d", v, i), rxd[23-8*i -: 8], vecs[v].exp_rx[23-8*i -: 8]);
      check($sformatf("v%0d_busy", v), {7'd0, busy}, 8'h00);
      check_q_empty($sformatf("v%0d_accesses", v));
    end

    // Abort: five bits of a write byte, then cs_n high; nothing may be written.
    spi_cs_n = 1'b0;
    #80;
    spi_xfer(8'h02, 8, r8);
    check("abort_busy_mid", {7'd0, busy}, 8'h01);
    spi_xfer(8'h40, 8, r8);
    spi_xfer(8'hC8, 5, r8);
    #80;
    spi_cs_n = 1'b1;
    #200;
    check("abort_busy", {7'd0, busy}, 8'h00);
    check("abort_idle", 8'(int'(dut.r_state)), 8'h00);
    check_q_empty("abort_accesses");
    run_frame(8'h02, 8'h40, 1, 24'h5A0000, rxd, hdr);
    check_q_empty("after_abort_wr");
    run_frame(8'h03, 8'h40, 1, 24'h000000, rxd, hdr);
    check("after_abort_rd", rxd[23:16], 8'h5A);
    check_q_empty("after_abort_rd_acc");

    // Reset mid-ADDR of a read: outputs return to reset values at once.
    spi_cs_n = 1'b0;
    #80;
    spi_xfer(8'h03, 8, r8);
    spi_xfer(8'hF0, 4, r8);
    #3 rst = 1'b1;
    #1;
    check("midrst_ss", {7'd0, ss}, 8'h01);
    check("midrst_re", {7'd0, re}, 8'h00);
    check("midrst_we", {7'd0, we}, 8'h00);
    check("midrst_addr", addr, 8'h00);
    check("midrst_miso", {7'd0, spi_miso}, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    spi_cs_n = 1'b1;
    #38 rst = 1'b0;
    #200;
    check_q_empty("midrst_accesses");
    run_frame(8'h03, 8'hFE, 2, 24'h000000, rxd, hdr);
    check("restart_rd0", rxd[23:16], 8'h11);
    check("restart_rd1", rxd[15:8], 8'h22);
    check_q_empty("restart_accesses");

    // The burst write must have wrapped from FF to 00.
    ea.a = 8'h00;
    check("wrap_mem00", mem[ea.a], 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
